// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 multiplier controller: digit-serial accumulation of operand magnitudes,
// sign fix-up, then half selection for MUL/MULH/MULHSU/MULHU.
module mul_seq_ctrl #(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int unsigned NumDigits = 32 / DIGIT_W;
    localparam logic [3:0]  LastCnt   = 4'(NumDigits - 1);

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fixed_q, fixed_d;
    logic [31:0] result_q, result_d;

    logic        rs1_signed, rs2_signed;
    logic [31:0] rs1_mag, rs2_mag;

    // Chain of 3:2 counters folds each shifted partial product into a carry-save pair seeded
    // with the accumulator; one carry-propagate add resolves it.
    function automatic logic [63:0] digit_accumulate(input logic [63:0]        acc,
                                                     input logic [31:0]        mcand,
                                                     input logic [DIGIT_W-1:0] digit,
                                                     input int unsigned        base);
        logic [63:0] s, c, pp, s_n, c_n;
        s = acc;
        c = '0;
        for (int i = 0; i < int'(DIGIT_W); i++) begin
            pp  = digit[i] ? (64'(mcand) << (base + 32'(i))) : 64'd0;
            s_n = s ^ c ^ pp;
            c_n = ((s & c) | (s & pp) | (c & pp)) << 1;
            s   = s_n;
            c   = c_n;
        end
        return s + c;
    endfunction

    // A 32-bit unsigned magnitude already holds 2^31, so 0x80000000 cannot overflow.
    always_comb begin
        rs1_signed = (op == OpMulh || op == OpMulhsu) && rs1[31];
        rs2_signed = (op == OpMulh) && rs2[31];
        rs1_mag    = rs1_signed ? (~rs1 + 32'd1) : rs1;
        rs2_mag    = rs2_signed ? (~rs2 + 32'd1) : rs2;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fixed_d  = fixed_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !kill) begin
                    op_d     = op;
                    mcand_d  = rs1_mag;
                    mplier_d = rs2_mag;
                    neg_d    = rs1_signed ^ rs2_signed;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StIter;
                end
            end
            StIter: begin
                acc_d    = digit_accumulate(acc_q, mcand_q, mplier_q[DIGIT_W-1:0],
                                            32'(cnt_q) * DIGIT_W);
                mplier_d = mplier_q >> DIGIT_W;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    fixed_d = 1'b0;
                    state_d = StFix;
                end
            end
            StFix: begin
                // Sign fix-up and half selection take separate edges.
                if (!fixed_q) begin
                    if (neg_q) acc_d = ~acc_q + 64'd1;
                    fixed_d = 1'b1;
                end else begin
                    result_d = (op_q == OpMul) ? acc_q[31:0] : acc_q[63:32];
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (kill) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            fixed_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fixed_q  <= fixed_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: driver pushes reference results, a negedge monitor
// checks latency, hold stability and result value at each output handshake.
module tb_mul_seq_ctrl;

    localparam int unsigned DigitW = 8;
    localparam int unsigned Lat    = 32 / DigitW + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    mul_seq_ctrl #(.DIGIT_W(DigitW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: extend operands per signedness, take the 64-bit product, pick a half.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_result = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!prev_valid)
                        check("latency", cyc - sb[0].acc_cyc, Lat);
                    else if (!prev_hs)
                        check("result_hold", result, prev_result);
                    if (out_ready && !kill) begin
                        check("result", result, sb[0].res);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_valid  = out_valid;
            prev_result = result;
            prev_hs     = out_valid && out_ready;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        e.res     = ref_mul(o, a, b);
        e.acc_cyc = cyc;
        if (push) sb.push_back(e);
        in_valid = 1'b0;
        op       = 2'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    // Wait until the scoreboard drains, jabbing in_valid/operands while busy.
    task automatic wait_idle(input bit rand_bp);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid  = busy ? 1'($urandom) : 1'b0;
            op        = 2'($urandom);
            rs1       = $urandom;
            rs2       = $urandom;
            if (sb.size() == 0 && in_ready) done = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;

        issue(2'b00, 32'h3, 32'h5, 1'b1);
        wait_idle(1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_idle(1'b0);

        // Backpressure for three DONE cycles, then handshake.
        out_ready = 1'b0;
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("hs_cycle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_out_valid", 32'(out_valid), 32'd0);

        // Kill in the second ITER cycle.
        issue(2'b00, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
        @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_in_ready", 32'(in_ready), 32'd1);
        check("kill_busy", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        issue(2'b00, 32'd2, 32'd7, 1'b1);
        wait_idle(1'b0);

        // Reset while in FIX.
        issue(2'b01, 32'hCAFE_F00D, 32'h8765_4321, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("fixrst_out_valid", 32'(out_valid), 32'd0);
        check("fixrst_result", result, 32'd0);
        check("fixrst_in_ready", 32'(in_ready), 32'd1);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_idle(1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), pick_operand(), pick_operand(), 1'b1);
            wait_idle(1'b1);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
